alu_result_stage: RTL and testbench

Execute-to-memory result stage for the 16-bit WISC pipeline, sitting directly downstream of the ALU and consuming its result and flag outputs (`out`, `ZF`, `CF`, `SF`, `OF`, `err`). It resolves flag-based branch conditions, buffers non-branch results in a 2-entry FIFO with a valid/ready handshake toward the memory stage, and keeps a last-flags register and a sticky error flag. It is the consumer end of the ALU result/flag interface.

---
 rtl/alu_result_stage_pkg.sv | 41 ++++
 rtl/alu_result_stage_fifo.sv | 46 ++++
 rtl/alu_result_stage.sv | 94 +++++++++
 tb/tb_alu_result_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the WISC execute-stage result path: branch codes,
// flag bit positions, result FIFO entry width and branch-condition helpers.
package wisc_ex_defs;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_EQ   = 3'd1;
   localparam logic [2:0] BR_NE   = 3'd2;
   localparam logic [2:0] BR_LT   = 3'd3;
   localparam logic [2:0] BR_GE   = 3'd4;

   localparam int FLG_Z = 3;
   localparam int FLG_C = 2;
   localparam int FLG_S = 1;
   localparam int FLG_O = 0;

   localparam int RES_ENTRY_W = 21;

   function automatic logic is_branch(input logic [2:0] cond);
      return (cond != BR_NONE) && (cond <= BR_GE);
   endfunction

   // Codes above BR_GE are reserved; such ops still flow through as results.
   function automatic logic is_reserved(input logic [2:0] cond);
      return cond > BR_GE;
   endfunction

   // Flags come from A-0, so they describe the tested register itself.
   function automatic logic br_eval(input logic [2:0] cond, input logic [3:0] flags);
      logic taken;
      taken = 1'b0;
      case (cond)
         BR_EQ:   taken = flags[FLG_Z];
         BR_NE:   taken = ~flags[FLG_Z];
         BR_LT:   taken = flags[FLG_S];
         BR_GE:   taken = ~flags[FLG_S];
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Two-entry result FIFO with 1-bit wrapping pointers, registered head, no bypass.
// Push-to-visible latency 1 cycle; flush clears occupancy and pointers, outranking push/pop.
module result_fifo2
   import wisc_ex_defs::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = RES_ENTRY_W,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// ALU result consumer: branch resolve (1-cycle br_taken pulse), 2-deep result FIFO,
// last-flags and sticky error. in_ready drops when the FIFO is full, no pass-through.
module alu_result_stage
   import wisc_ex_defs::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] alu_out,
   input  logic         zf,
   input  logic         cf,
   input  logic         sf,
   input  logic         of,
   input  logic         alu_err,
   input  logic [2:0]   br_cond,
   input  logic [W-1:0] br_target,
   input  logic         wr_en,
   input  logic [2:0]   wr_reg,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] res,
   output logic         res_wr_en,
   output logic [2:0]   res_wr_reg,
   output logic         res_err,
   output logic         br_taken,
   output logic [W-1:0] br_pc,
   output logic [3:0]   flags_q,
   output logic         err_q
);

   localparam int EW = W + 5;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count;
   logic [EW-1:0] entry_in;
   logic [EW-1:0] entry_head;
   logic [3:0]    flags_in;
   logic          accept;
   logic          branch_op;
   logic          push;
   logic          pop;
   logic          take;

   always_comb begin
      flags_in        = '0;
      flags_in[FLG_Z] = zf;
      flags_in[FLG_C] = cf;
      flags_in[FLG_S] = sf;
      flags_in[FLG_O] = of;
   end

   assign in_ready  = (count != CW'(DEPTH)) & rst_n;
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready & ~flush;
   assign branch_op = is_branch(br_cond);
   assign push      = accept & ~branch_op;
   assign pop       = out_valid & out_ready;
   assign take      = accept & branch_op & br_eval(br_cond, flags_in);
   assign entry_in  = {alu_out, wr_en, wr_reg, alu_err};

   result_fifo2 #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (entry_in),
      .dout  (entry_head),
      .count (count)
   );

   assign {res, res_wr_en, res_wr_reg, res_err} = entry_head;

   // br_pc holds the last taken target; it is only meaningful alongside br_taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken <= 1'b0;
         br_pc    <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         br_taken <= take;
         if (take) br_pc <= br_target;
         if (push) flags_q <= flags_in;
         if (accept & (alu_err | is_reserved(br_cond))) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: stimulus queues expected FIFO entries,
// a negedge monitor pops and compares them on every out_valid & out_ready.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_out;
   logic        zf, cf, sf, of;
   logic        alu_err;
   logic [2:0]  br_cond;
   logic [15:0] br_target;
   logic        wr_en;
   logic [2:0]  wr_reg;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] res;
   logic        res_wr_en;
   logic [2:0]  res_wr_reg;
   logic        res_err;
   logic        br_taken;
   logic [15:0] br_pc;
   logic [3:0]  flags_q;
   logic        err_q;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [20:0] exp_q[$];

   always #5 clk = ~clk;

   alu_result_stage #(.DEPTH(2), .W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .zf(zf), .cf(cf), .sf(sf), .of(of), .alu_err(alu_err),
      .br_cond(br_cond), .br_target(br_target), .wr_en(wr_en), .wr_reg(wr_reg),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .res(res),
      .res_wr_en(res_wr_en), .res_wr_reg(res_wr_reg), .res_err(res_err),
      .br_taken(br_taken), .br_pc(br_pc), .flags_q(flags_q), .err_q(err_q)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every handshake must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'({res, res_wr_en, res_wr_reg, res_err}), 32'hDEAD);
            end else begin
               check("fifo_head", 32'({res, res_wr_en, res_wr_reg, res_err}), 32'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] d, input logic we, input logic [2:0] rg,
                        input logic er, input logic [2:0] bc, input logic [15:0] tg,
                        input logic [3:0] fl);
      in_valid  = 1'b1;
      alu_out   = d;
      wr_en     = we;
      wr_reg    = rg;
      alu_err   = er;
      br_cond   = bc;
      br_target = tg;
      {zf, cf, sf, of} = fl;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic issue(input logic [15:0] d, input logic we, input logic [2:0] rg,
                        input logic er, input logic [2:0] bc, input logic [15:0] tg,
                        input logic [3:0] fl);
      drive(d, we, rg, er, bc, tg, fl);
      step();
      idle();
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b0;
      idle();
      drive(16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 4'h0);
      in_valid = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      check("rst_br_taken", 32'(br_taken), 32'd0);
      check("rst_flags_q", 32'(flags_q), 32'd0);
      check("rst_err_q", 32'(err_q), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Single push, popped immediately.
      out_ready = 1'b1;
      exp_q.push_back({16'h1234, 1'b1, 3'd5, 1'b0});
      issue(16'h1234, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0, 4'b0101);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_res", 32'(res), 32'h1234);
      check("t1_wr_reg", 32'(res_wr_reg), 32'd5);
      check("t1_flags_q", 32'(flags_q), 32'h5);
      step();
      check("t1_drained", 32'(out_valid), 32'd0);

      // Fill, third push refused, drain in order.
      out_ready = 1'b0;
      exp_q.push_back({16'hAAAA, 1'b1, 3'd1, 1'b0});
      exp_q.push_back({16'hBBBB, 1'b1, 3'd2, 1'b0});
      issue(16'hAAAA, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 4'b0101);
      issue(16'hBBBB, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 4'b0101);
      check("t2_full_ready", 32'(in_ready), 32'd0);
      drive(16'hCCCC, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 4'b0101);
      step();
      check("t2_still_full", 32'(in_ready), 32'd0);
      check("t2_head_held", 32'(res), 32'hAAAA);
      idle();
      out_ready = 1'b1;
      step();
      step();
      check("t2_drained", 32'(out_valid), 32'd0);

      // Branches: taken pulse, not taken, back-to-back taken.
      issue(16'h9999, 1'b1, 3'd4, 1'b0, 3'd3, 16'h0040, 4'b1010);
      check("t3_taken", 32'(br_taken), 32'd1);
      check("t3_pc", 32'(br_pc), 32'h0040);
      check("t3_no_enq", 32'(out_valid), 32'd0);
      check("t3_flags_kept", 32'(flags_q), 32'h5);
      step();
      check("t3_pulse_end", 32'(br_taken), 32'd0);
      issue(16'h9999, 1'b1, 3'd4, 1'b0, 3'd3, 16'h0080, 4'b0000);
      check("t3_not_taken", 32'(br_taken), 32'd0);
      drive(16'h0, 1'b0, 3'd0, 1'b0, 3'd1, 16'h0100, 4'b1000);
      step();
      check("t3_eq_taken", 32'(br_taken), 32'd1);
      check("t3_eq_pc", 32'(br_pc), 32'h0100);
      issue(16'h0, 1'b0, 3'd0, 1'b0, 3'd2, 16'h0200, 4'b0000);
      check("t3_ne_taken", 32'(br_taken), 32'd1);
      check("t3_ne_pc", 32'(br_pc), 32'h0200);
      step();
      check("t3_ne_pulse_end", 32'(br_taken), 32'd0);

      // Simultaneous push/pop at count 1, then flush with push.
      out_ready = 1'b0;
      exp_q.push_back({16'h0001, 1'b1, 3'd1, 1'b0});
      issue(16'h0001, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 4'b0000);
      out_ready = 1'b1;
      exp_q.push_back({16'h0002, 1'b1, 3'd2, 1'b0});
      issue(16'h0002, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 4'b0000);
      out_ready = 1'b0;
      check("t4_pushpop_valid", 32'(out_valid), 32'd1);
      check("t4_pushpop_head", 32'(res), 32'h0002);
      issue(16'h0003, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 4'b0010);
      check("t4_full", 32'(in_ready), 32'd0);
      drive(16'h0004, 1'b1, 3'd4, 1'b1, 3'd0, 16'h0, 4'b1111);
      flush = 1'b1;
      step();
      idle();
      exp_q.delete();
      check("t4_flush_valid", 32'(out_valid), 32'd0);
      check("t4_flush_flags", 32'(flags_q), 32'h2);
      check("t4_flush_err", 32'(err_q), 32'd0);
      check("t4_flush_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      exp_q.push_back({16'h0005, 1'b0, 3'd6, 1'b0});
      issue(16'h0005, 1'b0, 3'd6, 1'b0, 3'd0, 16'h0, 4'b0010);
      check("t4_after_flush", 32'(res), 32'h0005);

      // Sticky error.
      exp_q.push_back({16'h0006, 1'b1, 3'd1, 1'b1});
      issue(16'h0006, 1'b1, 3'd1, 1'b1, 3'd0, 16'h0, 4'b0000);
      check("t5_err_set", 32'(err_q), 32'd1);
      exp_q.push_back({16'h0007, 1'b1, 3'd2, 1'b0});
      issue(16'h0007, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 4'b0000);
      check("t5_err_sticky", 32'(err_q), 32'd1);
      step();

      // Async reset mid-cycle with an entry and a pending pulse.
      out_ready = 1'b0;
      exp_q.push_back({16'hABCD, 1'b1, 3'd7, 1'b1});
      issue(16'hABCD, 1'b1, 3'd7, 1'b1, 3'd0, 16'h0, 4'b1111);
      issue(16'h0, 1'b0, 3'd0, 1'b0, 3'd1, 16'h00F0, 4'b1000);
      check("t6_pulse_pending", 32'(br_taken), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_head", 32'({res, res_wr_en, res_wr_reg, res_err}), 32'd0);
      check("t6_rst_br", 32'({br_taken, br_pc}), 32'd0);
      check("t6_rst_flags_err", 32'({flags_q, err_q}), 32'd0);
      check("t6_rst_ready", 32'(in_ready), 32'd0);
      step();
      rst_n = 1'b1;

      // Reserved branch code is enqueued and flags an error.
      out_ready = 1'b1;
      exp_q.push_back({16'h0008, 1'b0, 3'd0, 1'b0});
      issue(16'h0008, 1'b0, 3'd0, 1'b0, 3'd6, 16'h0300, 4'b0100);
      check("t7_reserved_err", 32'(err_q), 32'd1);
      check("t7_reserved_enq", 32'(out_valid), 32'd1);
      check("t7_reserved_flags", 32'(flags_q), 32'h4);
      check("t7_no_branch", 32'(br_taken), 32'd0);
      step();
      step();
      check("all_expected_popped", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
